wb_scheduler: RTL and testbench

Writeback scheduler for the Y86 register file. It accepts per-instruction writeback requests, each carrying up to two destinations (dstE/valE and dstM/valM), and buffers them in an in-order FIFO. It drains them into a single-write-port register file at one write per cycle. A pending-write lookup port lets decode forward values that are queued but not yet committed.

---
 rtl/wb_scheduler_if.sv | 36 +++
 rtl/wb_scheduler.sv | 163 ++++++++++++++++
 tb/tb_wb_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_scheduler_if.sv
// Request, writeback and pending-lookup signals of the Y86 writeback scheduler.
// The scheduler takes the slave modport. Decode/execute and the register file
// side take the master modport.
interface wb_scheduler_if #(
  parameter int WIDTH = 64
) ();
  // Writeback request handshake.
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_dstE;
  logic [WIDTH-1:0] req_valE;
  logic [3:0]       req_dstM;
  logic [WIDTH-1:0] req_valM;

  // Single register-file write port.
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  // Pending-write lookup used for forwarding into decode.
  logic [3:0]       rd_addr;
  logic             pend_hit;
  logic [WIDTH-1:0] pend_data;

  logic             idle;

  modport slave (
    input  req_valid, req_dstE, req_valE, req_dstM, req_valM, rd_addr,
    output req_ready, wr_en, wr_addr, wr_data, pend_hit, pend_data, idle
  );

  modport master (
    output req_valid, req_dstE, req_valE, req_dstM, req_valM, rd_addr,
    input  req_ready, wr_en, wr_addr, wr_data, pend_hit, pend_data, idle
  );
endinterface

// File: rtl/wb_scheduler.sv
// Writeback scheduler for the Y86 register file.
// Requests carry up to two destinations (E and M). They are normalised and
// buffered in an in-order FIFO, then drained at one register-file write per
// cycle. A combinational lookup exposes queued writes that have not yet
// committed, so decode can forward them.
//
//   state  | meaning
//   S_IDLE | FIFO empty, no write on the port
//   S_E    | head entry's E half is on the write port
//   S_M    | head entry's M half is on the write port (E half done or absent)
module wb_scheduler #(
  parameter int         DEPTH = 4,
  parameter int         WIDTH = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input logic           clk_i,
  input logic           reset_i,
  wb_scheduler_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_E, S_M} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [3:0]       dste_q [DEPTH];
  logic [WIDTH-1:0] vale_q [DEPTH];
  logic [3:0]       dstm_q [DEPTH];
  logic [WIDTH-1:0] valm_q [DEPTH];

  logic             req_ready;
  logic             push;
  logic             store;
  logic [3:0]       new_dste;
  logic             pop;
  logic [3:0]       head_dste;
  logic [3:0]       head_dstm;
  logic [CW-1:0]    remain;
  logic [3:0]       nxt_dste;
  state_t           nxt_first;

  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             pend_hit;
  logic [WIDTH-1:0] pend_data;

  // Ready depends only on the registered count. A pop in the same cycle
  // does not free a slot until the next cycle.
  assign req_ready = (count_q < CW'(DEPTH));
  assign push      = bus.req_valid && req_ready;
  // A request with no destinations completes the handshake but is not stored.
  assign store     = push && !((bus.req_dstE == RNONE) && (bus.req_dstM == RNONE));
  // Same destination on both halves: M wins, so the E half is dropped.
  assign new_dste  = (bus.req_dstE == bus.req_dstM) ? RNONE : bus.req_dstE;

  assign head_dste = dste_q[rptr_q];
  assign head_dstm = dstm_q[rptr_q];
  // The head retires after its last valid half has been presented.
  assign pop       = ((state_q == S_E) && (head_dstm == RNONE)) || (state_q == S_M);

  // Next pointers, count and state. The next head is either an entry already
  // in the FIFO, or the request being pushed now when nothing else remains.
  always_comb begin
    rptr_d    = pop   ? rptr_q + AW'(1) : rptr_q;
    wptr_d    = store ? wptr_q + AW'(1) : wptr_q;
    count_d   = count_q + CW'(store) - CW'(pop);
    remain    = count_q - CW'(pop);
    nxt_dste  = (remain == '0) ? new_dste : dste_q[rptr_d];
    nxt_first = S_IDLE;
    if (count_d != '0) begin
      nxt_first = (nxt_dste != RNONE) ? S_E : S_M;
    end
    state_d = nxt_first;
    if ((state_q == S_E) && (head_dstm != RNONE)) begin
      state_d = S_M;
    end
  end

  // State, pointer, count and FIFO storage registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dste_q[i] <= RNONE;
        vale_q[i] <= '0;
        dstm_q[i] <= RNONE;
        valm_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      if (store) begin
        dste_q[wptr_q] <= new_dste;
        vale_q[wptr_q] <= bus.req_valE;
        dstm_q[wptr_q] <= bus.req_dstM;
        valm_q[wptr_q] <= bus.req_valM;
      end
    end
  end

  // Write port, decoded directly from state and head entry.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      S_E: begin
        wr_en   = 1'b1;
        wr_addr = head_dste;
        wr_data = vale_q[rptr_q];
      end
      S_M: begin
        wr_en   = 1'b1;
        wr_addr = head_dstm;
        wr_data = valm_q[rptr_q];
      end
      default: ;
    endcase
  end

  // Pending lookup. Entries are scanned oldest to youngest so later matches
  // override earlier ones, and M is checked after E within each entry. The head's
  // E half is skipped in S_M because it has already been committed.
  always_comb begin
    logic [AW-1:0] idx;
    idx       = '0;
    pend_hit  = 1'b0;
    pend_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + AW'(i);
      if ((CW'(i) < count_q) && (bus.rd_addr != RNONE)) begin
        if ((dste_q[idx] == bus.rd_addr) && !((i == 0) && (state_q == S_M))) begin
          pend_hit  = 1'b1;
          pend_data = vale_q[idx];
        end
        if (dstm_q[idx] == bus.rd_addr) begin
          pend_hit  = 1'b1;
          pend_data = valm_q[idx];
        end
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.pend_hit  = pend_hit;
  assign bus.pend_data = pend_data;
  assign bus.idle      = (state_q == S_IDLE);

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler.
// When a request is accepted, the reference model expands it into the list of
// register writes it must produce. The monitor then consumes that list as
// writes appear on the port. The same list of uncommitted writes also gives
// the expected pending-lookup result, the FIFO occupancy and idle.
module tb_wb_scheduler;
  localparam int         DEPTH = 4;
  localparam int         WIDTH = 64;
  localparam logic [3:0] RNONE = 4'hF;

  logic clk = 1'b0;
  logic reset = 1'b1;

  wb_scheduler_if #(.WIDTH(WIDTH)) bus ();

  wb_scheduler #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RNONE(RNONE)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       addr;
    logic [WIDTH-1:0] data;
    int               id;
  } wr_t;

  wr_t expq[$];
  int  next_id   = 0;
  int  n_cmp     = 0;
  int  n_bad     = 0;
  int  fwd_seen  = 0;
  int  timeouts  = 0;
  int  mon_cnt;
  bit  saw_full  = 1'b0;
  bit  rd_rand   = 1'b0;
  bit  done      = 1'b0;
  bit  chk_rst   = 1'b0;
  logic             exp_hit;
  logic [WIDTH-1:0] exp_pd;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the writes an accepted request must eventually produce.
  task automatic model_accept(input logic [3:0] de, input logic [WIDTH-1:0] ve,
                              input logic [3:0] dm, input logic [WIDTH-1:0] vm);
    bit any;
    any = 1'b0;
    if (de != RNONE && de != dm) begin
      expq.push_back('{addr: de, data: ve, id: next_id});
      any = 1'b1;
    end
    if (dm != RNONE) begin
      expq.push_back('{addr: dm, data: vm, id: next_id});
      any = 1'b1;
    end
    if (any) next_id++;
  endtask

  // Youngest uncommitted write to a register wins.
  task automatic model_pend(input logic [3:0] ra, output logic hit, output logic [WIDTH-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (ra != RNONE) begin
      for (int k = expq.size() - 1; k >= 0; k--) begin
        if (expq[k].addr == ra) begin
          hit = 1'b1;
          d   = expq[k].data;
          break;
        end
      end
    end
  endtask

  // Monitor: record acceptances at the clock edge, check outputs mid-cycle.
  always begin
    @(posedge clk);
    if (reset) expq.delete();
    else if (bus.req_valid && bus.req_ready)
      model_accept(bus.req_dstE, bus.req_valE, bus.req_dstM, bus.req_valM);
    @(negedge clk);
    if (!reset) begin
      mon_cnt = (expq.size() == 0) ? 0 : (expq[$].id - expq[0].id + 1);
      check("req_ready", bus.req_ready, mon_cnt < DEPTH);
      check("idle", bus.idle, expq.size() == 0);
      check("wr_en", bus.wr_en, expq.size() != 0);
      model_pend(bus.rd_addr, exp_hit, exp_pd);
      check("pend_hit", bus.pend_hit, exp_hit);
      check("pend_data", bus.pend_data, exp_pd);
      if (exp_hit && bus.rd_addr == 4'd5 && exp_pd == 64'h2) fwd_seen++;
      if (!bus.req_ready) saw_full = 1'b1;
      if (chk_rst) begin
        check("reset wr_addr", bus.wr_addr, 0);
        check("reset wr_data", bus.wr_data, 0);
      end
      if (bus.wr_en && expq.size() != 0) begin
        check("wr_addr", bus.wr_addr, expq[0].addr);
        check("wr_data", bus.wr_data, expq[0].data);
        void'(expq.pop_front());
      end
      if (done) begin
        check("backpressure seen", saw_full, 1);
        check("forward hit seen", fwd_seen > 0, 1);
        check("send timeouts", timeouts, 0);
        check("writes outstanding", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rd_rand) bus.rd_addr = 4'($urandom_range(0, 15));
  endtask

  task automatic send(input logic [3:0] de, input logic [WIDTH-1:0] ve,
                      input logic [3:0] dm, input logic [WIDTH-1:0] vm);
    int budget;
    budget = 100;
    bus.req_valid = 1'b1;
    bus.req_dstE  = de;
    bus.req_valE  = ve;
    bus.req_dstM  = dm;
    bus.req_valM  = vm;
    while (!bus.req_ready && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) timeouts++;
    cycle();
  endtask

  task automatic release_bus();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 100;
    cycle();
    while (!bus.idle && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) timeouts++;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_dstE  = RNONE;
    bus.req_valE  = '0;
    bus.req_dstM  = RNONE;
    bus.req_valM  = '0;
    bus.rd_addr   = 4'd0;
    reset = 1'b1;
    repeat (3) cycle();
    reset   = 1'b0;
    chk_rst = 1'b1;
    cycle();
    chk_rst = 1'b0;

    // Single write, dual write, same-destination collapse, empty request.
    send(4'd3, 64'h11, RNONE, 64'h0);    release_bus(); wait_idle();
    send(4'd4, 64'h1F8, 4'd2, 64'hAB);   release_bus(); wait_idle();
    send(4'd4, 64'h10, 4'd4, 64'h99);    release_bus(); wait_idle();
    send(RNONE, 64'h55, RNONE, 64'h66);  release_bus(); repeat (3) cycle();

    // Backpressure: six dual requests held back to back.
    for (int i = 0; i < 6; i++)
      send(4'(i), 64'h100 + 64'(i), 4'(i + 8), 64'h200 + 64'(i));
    release_bus(); wait_idle();

    // Forwarding on r5, then with the lookup disabled by RNONE.
    bus.rd_addr = 4'd5;
    send(4'd5, 64'h1, RNONE, 64'h0);
    send(RNONE, 64'h0, 4'd5, 64'h2);
    release_bus(); wait_idle(); repeat (2) cycle();
    bus.rd_addr = RNONE;
    send(4'd5, 64'h7, 4'd6, 64'h8);
    send(RNONE, 64'h0, RNONE, 64'h0);
    send(4'd15, 64'h9, 4'd5, 64'h3);
    release_bus(); wait_idle();

    // Reset while the second entry's M half is on the port, three entries queued.
    send(4'd1, 64'hA1, 4'd2, 64'hA2);
    send(4'd3, 64'hA3, 4'd4, 64'hA4);
    send(4'd5, 64'hA5, 4'd6, 64'hA6);
    send(4'd7, 64'hA7, 4'd8, 64'hA8);
    release_bus();
    for (int b = 0; b < 20 && !(bus.wr_en && bus.wr_addr == 4'd4); b++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (8) cycle();

    // Randomised traffic with random lookup addresses.
    rd_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [3:0] de, dm;
      release_bus();
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0) cycle();
      de = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 14));
      dm = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 14));
      if ($urandom_range(0, 9) == 0) dm = de;
      send(de, {$urandom, $urandom}, dm, {$urandom, $urandom});
    end
    release_bus();
    wait_idle();
    done = 1'b1;
    repeat (5) cycle();
  end

endmodule
